pic_ack_sequencer: RTL and testbench
====================================

Name: pic_ack_sequencer

Overview:
Sequences the 8259 interrupt-acknowledge cycle around the request register and priority resolver. It resolves the masked IRR against the in-service state under fully-nested or rotating priority, and drives INT to the CPU. It steps through the two-INTA handshake, setting ISR, clearing the IRR bit and emitting the vector. It owns the ISR and handles AEOI and non-specific/specific EOI.

Parameters:
INTA_TIMEOUT, 255, cycles allowed in ACK1 waiting for the second INTA before abort
TIMEOUT_W, 8, width of timeout counter (must hold INTA_TIMEOUT)

Ports:
CLK  in  1  system clock
RST  in  1  synchronous active-high reset
IRR  in  8  masked interrupt request bits (IRR & ~IMR)
INTA_PULSE  in  1  one-cycle strobe per CPU INTA (synchronised upstream)
VECTOR_BASE  in  5  ICW2 T7..T3
AEOI  in  1  1 = automatic EOI on second INTA
ROTATE_MODE  in  1  1 = rotate priority on EOI, 0 = fully nested
EOI_CMD  in  1  one-cycle non-specific EOI strobe (OCW2)
SEOI_CMD  in  1  one-cycle specific EOI strobe
SEOI_LEVEL  in  3  level for specific EOI
INT  out  1  interrupt request to CPU, registered
IRR_CLR  out  8  one-hot, one-cycle clear to request register
ISR  out  8  in-service register
DATA_OUT  out  8  vector / poll word
DATA_VALID  out  1  one-cycle qualifier for DATA_OUT

Behaviour:
- Reset values: INT=0, IRR_CLR=0, ISR=0, DATA_OUT=0, DATA_VALID=0, state=IDLE, LP (lowest-priority pointer)=7, timeout=0.
- Priority order: highest = (P+1) mod 8 descending to P, where P=LP if ROTATE_MODE=1, else P=7. LP is held when ROTATE_MODE=0.
- Candidate: highest-priority set IRR bit strictly above the highest-priority set ISR bit. Valid only if such a bit exists.
- IDLE: candidate valid -> REQ; INT=1 on the following cycle. An IRR bit set at cycle n gives INT high at n+1. INTA_PULSE in IDLE is ignored.
- REQ: INT held 1. On INTA_PULSE:
  - Latch candidate level L, set ISR[L], pulse IRR_CLR[L] for exactly 1 cycle, INT=0, go to ACK1.
  - If the candidate vanished, latch L=7 as spurious: no ISR set, no IRR_CLR.
- ACK1: timeout counts up.
  - On INTA_PULSE: DATA_OUT={VECTOR_BASE,L}, DATA_VALID=1 for 1 cycle. If AEOI and not spurious, clear ISR[L] (LP:=L when ROTATE_MODE). Go to IDLE.
  - On timeout==INTA_TIMEOUT: clear ISR[L], no vector, go to IDLE. IRR is not restored.
- Back-to-back: INT may reassert the cycle after IDLE re-entry if a candidate exists.
- Non-specific EOI: clear highest-priority set ISR bit under the current order. If ROTATE_MODE, LP:=that level. No-op when ISR=0.
- Specific EOI: clear ISR[SEOI_LEVEL]. If ROTATE_MODE, LP:=SEOI_LEVEL. Clearing an already-clear bit is a no-op except for the rotation.
- Simultaneous events, single cycle:
  - EOI is evaluated on the pre-update ISR.
  - ISR set from ACK1 entry wins over an EOI clear of the same bit.
  - EOI_CMD and SEOI_CMD together: SEOI takes precedence.
  - AEOI clear and EOI in the same cycle both apply.
- IRR changes during ACK1 do not alter L.
- RST mid-handshake returns every register to reset values next edge. DATA_VALID and IRR_CLR never remain high.

Optional Feature:
POLL_EN: adds input POLL_CMD (1-cycle strobe), valid only in IDLE or REQ.
- With macro: next cycle DATA_OUT={1'b1,4'b0,L} and DATA_VALID=1. If a candidate exists, ISR[L] is set and IRR_CLR[L] is pulsed as on the first INTA, and state returns to IDLE with INT=0. With no candidate, DATA_OUT=8'h00.
- Without macro: port absent, no poll logic.

Test Plan:
- IRR=8'h08, VECTOR_BASE=5'b01000, AEOI=0 -> INT=1 next cycle. INTA#1 -> ISR=8'h08, IRR_CLR=8'h08 for 1 cycle, INT=0. INTA#2 -> DATA_OUT=8'h43, DATA_VALID 1 cycle, ISR stays 8'h08.
- ISR=8'h08 active, IRR=8'h21 -> IR0 preempts (ISR=8'h09). IR5 waits until EOI_CMD clears IR0 then IR3, after which INT reasserts for IR5.
- ROTATE_MODE=1, AEOI=1, IRR=8'hFF held -> successive vectors for levels 0,1,2...7,0. LP tracks the last serviced level.
- IRR=8'h10 raises INT, IRR drops to 0 before INTA#1 -> ISR unchanged, no IRR_CLR, INTA#2 gives DATA_OUT={VECTOR_BASE,3'd7}.
- INTA#1 then no INTA#2 for INTA_TIMEOUT cycles -> ISR bit cleared, no DATA_VALID, INT reasserts only if a new candidate exists.
- RST asserted in ACK1 with ISR=8'h04 -> next edge ISR=0, INT=0, LP=7, state IDLE. A later INTA_PULSE is ignored.

Source files
------------

// File: rtl/pic_ack_sequencer.sv
// 8259 interrupt-acknowledge sequencer: priority resolve, INT, two-INTA handshake, ISR/EOI ownership.
// Latency: IRR bit -> INT one cycle; INTA -> ISR/IRR_CLR/vector registered one cycle later.
// Backpressure: none; INTA/EOI strobes are single-cycle and always accepted when the state allows them.
//
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   IRR                      masked request bits from the request register
//   INTA_PULSE               one strobe per CPU INTA
//   VECTOR_BASE              upper five vector bits (T7..T3)
//   AEOI, ROTATE_MODE        automatic EOI enable, rotating-priority enable
//   EOI_CMD, SEOI_CMD/LEVEL  non-specific and specific EOI strobes
//   POLL_CMD                 poll strobe (only when POLL_EN is defined)
//   INT                      registered interrupt request to the CPU
//   IRR_CLR                  one-hot, one-cycle clear back to the request register
//   ISR                      in-service register
//   DATA_OUT, DATA_VALID     vector / poll word with one-cycle qualifier
//
// Optional feature macro: POLL_EN (adds POLL_CMD and the poll-word path).
module pic_ack_sequencer #(
    parameter int INTA_TIMEOUT = 255,
    parameter int TIMEOUT_W    = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] IRR,
    input  logic       INTA_PULSE,
    input  logic [4:0] VECTOR_BASE,
    input  logic       AEOI,
    input  logic       ROTATE_MODE,
    input  logic       EOI_CMD,
    input  logic       SEOI_CMD,
    input  logic [2:0] SEOI_LEVEL,
`ifdef POLL_EN
    input  logic       POLL_CMD,
`endif
    output logic       INT,
    output logic [7:0] IRR_CLR,
    output logic [7:0] ISR,
    output logic [7:0] DATA_OUT,
    output logic       DATA_VALID
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACK1} state_e;

    localparam logic [TIMEOUT_W-1:0] TIMEOUT_MAX = TIMEOUT_W'(INTA_TIMEOUT);

    // Reorder a level vector so bit 0 is the highest priority level (P+1).
    function automatic logic [7:0] rotate_order(input logic [7:0] v, input logic [2:0] p);
        logic [7:0] r;
        logic [2:0] idx;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            idx  = p + 3'd1 + 3'(k);
            r[k] = v[idx];
        end
        return r;
    endfunction

    // Rank of the highest-priority set bit; 8 means none set.
    function automatic logic [3:0] first_rank(input logic [7:0] r);
        logic [3:0] rank;
        rank = 4'd8;
        for (int k = 7; k >= 0; k--) begin
            if (r[k]) rank = 4'(k);
        end
        return rank;
    endfunction

    state_e                 state_q, state_d;
    logic                   int_q, int_d;
    logic [7:0]             irr_clr_q, irr_clr_d;
    logic [7:0]             isr_q, isr_d;
    logic [7:0]             data_out_q, data_out_d;
    logic                   data_valid_q, data_valid_d;
    logic [2:0]             lp_q, lp_d;
    logic [2:0]             lvl_q, lvl_d;
    logic                   spur_q, spur_d;
    logic [TIMEOUT_W-1:0]   timeout_q, timeout_d;

    logic [2:0] prio_p;
    logic [3:0] irr_rank, isr_rank;
    logic       cand_vld, isr_top_vld, timeout_hit;
    logic [2:0] cand_lvl, isr_top_lvl;
    logic [7:0] isr_set, hs_clr, eoi_clr;

    // Candidate must outrank every in-service level; an absent ISR ranks 8.
    assign prio_p      = ROTATE_MODE ? lp_q : 3'd7;
    assign irr_rank    = first_rank(rotate_order(IRR, prio_p));
    assign isr_rank    = first_rank(rotate_order(isr_q, prio_p));
    assign cand_vld    = (irr_rank < isr_rank);
    assign cand_lvl    = prio_p + 3'd1 + irr_rank[2:0];
    assign isr_top_vld = ~isr_rank[3];
    assign isr_top_lvl = prio_p + 3'd1 + isr_rank[2:0];
    assign timeout_hit = (timeout_q == TIMEOUT_MAX);

    // State register and all datapath registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= S_IDLE;
            int_q        <= 1'b0;
            irr_clr_q    <= '0;
            isr_q        <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            lp_q         <= 3'd7;
            lvl_q        <= 3'd0;
            spur_q       <= 1'b0;
            timeout_q    <= '0;
        end else begin
            state_q      <= state_d;
            int_q        <= int_d;
            irr_clr_q    <= irr_clr_d;
            isr_q        <= isr_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            lp_q         <= lp_d;
            lvl_q        <= lvl_d;
            spur_q       <= spur_d;
            timeout_q    <= timeout_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
`ifdef POLL_EN
                if (POLL_CMD)      state_d = S_IDLE;
                else
`endif
                if (cand_vld)      state_d = S_REQ;
            end
            S_REQ: begin
                if (INTA_PULSE)    state_d = S_ACK1;
`ifdef POLL_EN
                else if (POLL_CMD) state_d = S_IDLE;
`endif
            end
            S_ACK1: begin
                if (INTA_PULSE || timeout_hit) state_d = S_IDLE;
            end
            default:               state_d = S_IDLE;
        endcase
    end

    // Output / datapath next values.
    always_comb begin
        irr_clr_d    = '0;
        data_valid_d = 1'b0;
        data_out_d   = data_out_q;
        lvl_d        = lvl_q;
        spur_d       = spur_q;
        lp_d         = lp_q;
        timeout_d    = '0;
        isr_set      = '0;
        hs_clr       = '0;
        eoi_clr      = '0;

        case (state_q)
            S_REQ: begin
                if (INTA_PULSE) begin
                    // A vanished candidate is acknowledged as spurious IR7.
                    lvl_d  = cand_vld ? cand_lvl : 3'd7;
                    spur_d = ~cand_vld;
                    if (cand_vld) begin
                        isr_set[cand_lvl]   = 1'b1;
                        irr_clr_d[cand_lvl] = 1'b1;
                    end
                end
            end
            S_ACK1: begin
                timeout_d = timeout_q + TIMEOUT_W'(1);
                if (INTA_PULSE) begin
                    data_out_d   = {VECTOR_BASE, lvl_q};
                    data_valid_d = 1'b1;
                    if (AEOI && !spur_q) begin
                        hs_clr[lvl_q] = 1'b1;
                        if (ROTATE_MODE) lp_d = lvl_q;
                    end
                end else if (timeout_hit && !spur_q) begin
                    hs_clr[lvl_q] = 1'b1;
                end
            end
            default: ;
        endcase

`ifdef POLL_EN
        if (POLL_CMD && (state_q != S_ACK1) && !((state_q == S_REQ) && INTA_PULSE)) begin
            data_valid_d = 1'b1;
            data_out_d   = cand_vld ? {1'b1, 4'b0000, cand_lvl} : 8'h00;
            if (cand_vld) begin
                isr_set[cand_lvl]   = 1'b1;
                irr_clr_d[cand_lvl] = 1'b1;
            end
        end
`endif

        // EOI sees the pre-update ISR; specific EOI outranks non-specific.
        if (SEOI_CMD) begin
            eoi_clr[SEOI_LEVEL] = 1'b1;
            if (ROTATE_MODE) lp_d = SEOI_LEVEL;
        end else if (EOI_CMD && isr_top_vld) begin
            eoi_clr[isr_top_lvl] = 1'b1;
            if (ROTATE_MODE) lp_d = isr_top_lvl;
        end

        // A set from the handshake wins over any clear of the same bit.
        isr_d = (isr_q & ~hs_clr & ~eoi_clr) | isr_set;
        int_d = (state_d == S_REQ);
    end

    assign INT        = int_q;
    assign IRR_CLR    = irr_clr_q;
    assign ISR        = isr_q;
    assign DATA_OUT   = data_out_q;
    assign DATA_VALID = data_valid_q;

endmodule

// File: tb/tb_pic_ack_sequencer.sv
module tb_pic_ack_sequencer;

    localparam int TO = 255;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] IRR = '0;
    logic       INTA_PULSE = 1'b0;
    logic [4:0] VECTOR_BASE = '0;
    logic       AEOI = 1'b0;
    logic       ROTATE_MODE = 1'b0;
    logic       EOI_CMD = 1'b0;
    logic       SEOI_CMD = 1'b0;
    logic [2:0] SEOI_LEVEL = '0;
    logic       INT;
    logic [7:0] IRR_CLR;
    logic [7:0] ISR;
    logic [7:0] DATA_OUT;
    logic       DATA_VALID;

    int n_cmp = 0;
    int n_err = 0;
    int lp_m  = 7;   // model of the lowest-priority pointer

    pic_ack_sequencer #(.INTA_TIMEOUT(TO), .TIMEOUT_W(8)) dut (
        .CLK(CLK), .RST(RST), .IRR(IRR), .INTA_PULSE(INTA_PULSE),
        .VECTOR_BASE(VECTOR_BASE), .AEOI(AEOI), .ROTATE_MODE(ROTATE_MODE),
        .EOI_CMD(EOI_CMD), .SEOI_CMD(SEOI_CMD), .SEOI_LEVEL(SEOI_LEVEL),
        .INT(INT), .IRR_CLR(IRR_CLR), .ISR(ISR), .DATA_OUT(DATA_OUT),
        .DATA_VALID(DATA_VALID)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Walk levels from highest priority (p+1) downward; an in-service level
    // reached first blocks everything below it.
    function automatic int m_cand(input logic [7:0] irr, input logic [7:0] isr, input int p);
        for (int k = 0; k < 8; k++) begin
            int l;
            l = (p + 1 + k) % 8;
            if (isr[l]) return -1;
            if (irr[l]) return l;
        end
        return -1;
    endfunction

    function automatic int m_p();
        return ROTATE_MODE ? lp_m : 7;
    endfunction

    task automatic clk(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic pulse_inta();
        INTA_PULSE = 1'b1; clk(1); INTA_PULSE = 1'b0;
    endtask

    task automatic pulse_eoi();
        EOI_CMD = 1'b1; clk(1); EOI_CMD = 1'b0;
    endtask

    task automatic pulse_seoi(input int lvl);
        SEOI_CMD = 1'b1; SEOI_LEVEL = 3'(lvl); clk(1); SEOI_CMD = 1'b0;
    endtask

    // Full handshake for a single request level, no checks.
    task automatic service(input int lvl);
        IRR = 8'b1 << lvl; clk(1); pulse_inta(); IRR = '0; pulse_inta();
    endtask

    task automatic test_reset();
        n_cmp++; if (INT !== 1'b0) begin n_err++; $display("FAIL reset_int: got %b want 0", INT); end
        n_cmp++; if (IRR_CLR !== 8'h00) begin n_err++; $display("FAIL reset_irr_clr: got %h want 00", IRR_CLR); end
        n_cmp++; if (ISR !== 8'h00) begin n_err++; $display("FAIL reset_isr: got %h want 00", ISR); end
        n_cmp++; if (DATA_OUT !== 8'h00) begin n_err++; $display("FAIL reset_data_out: got %h want 00", DATA_OUT); end
        n_cmp++; if (DATA_VALID !== 1'b0) begin n_err++; $display("FAIL reset_data_valid: got %b want 0", DATA_VALID); end
    endtask

    task automatic test_basic(input int lvl, input logic [4:0] vb);
        logic [7:0] m;
        logic [2:0] l3;
        m = 8'b1 << lvl; l3 = 3'(lvl);
        VECTOR_BASE = vb; AEOI = 0; ROTATE_MODE = 0;
        IRR = m; clk(1);
        n_cmp++; if (INT !== 1'b1) begin n_err++; $display("FAIL basic_int: got %b want 1", INT); end
        pulse_inta();
        n_cmp++; if (ISR !== m) begin n_err++; $display("FAIL basic_isr_set: got %h want %h", ISR, m); end
        n_cmp++; if (IRR_CLR !== m) begin n_err++; $display("FAIL basic_irr_clr: got %h want %h", IRR_CLR, m); end
        n_cmp++; if (INT !== 1'b0) begin n_err++; $display("FAIL basic_int_drop: got %b want 0", INT); end
        IRR = '0; clk(1);
        n_cmp++; if (IRR_CLR !== 8'h00) begin n_err++; $display("FAIL basic_irr_clr_pulse: got %h want 00", IRR_CLR); end
        pulse_inta();
        n_cmp++; if (DATA_VALID !== 1'b1 || DATA_OUT !== {vb, l3}) begin
            n_err++; $display("FAIL basic_vector: got %b/%h want 1/%h", DATA_VALID, DATA_OUT, {vb, l3}); end
        clk(1);
        n_cmp++; if (DATA_VALID !== 1'b0) begin n_err++; $display("FAIL basic_valid_pulse: got %b want 0", DATA_VALID); end
        n_cmp++; if (ISR !== m) begin n_err++; $display("FAIL basic_isr_hold: got %h want %h", ISR, m); end
        pulse_seoi(lvl);
        n_cmp++; if (ISR !== 8'h00) begin n_err++; $display("FAIL basic_seoi: got %h want 00", ISR); end
    endtask

    task automatic test_nesting();
        logic [4:0] vb;
        vb = 5'($urandom); VECTOR_BASE = vb; AEOI = 0; ROTATE_MODE = 0;
        service(3);
        IRR = 8'h21; clk(1);
        n_cmp++; if (INT !== 1'b1) begin n_err++; $display("FAIL nest_int: got %b want 1", INT); end
        pulse_inta();
        n_cmp++; if (ISR !== 8'h09 || IRR_CLR !== 8'h01) begin
            n_err++; $display("FAIL nest_preempt: got isr %h clr %h want 09/01", ISR, IRR_CLR); end
        IRR = 8'h20; pulse_inta();
        n_cmp++; if (DATA_OUT !== {vb, 3'd0}) begin n_err++; $display("FAIL nest_vec0: got %h want %h", DATA_OUT, {vb, 3'd0}); end
        clk(2);
        n_cmp++; if (INT !== 1'b0) begin n_err++; $display("FAIL nest_ir5_blocked: got %b want 0", INT); end
        pulse_eoi();
        n_cmp++; if (ISR !== 8'h08) begin n_err++; $display("FAIL nest_eoi0: got %h want 08", ISR); end
        clk(2);
        n_cmp++; if (INT !== 1'b0) begin n_err++; $display("FAIL nest_ir5_still_blocked: got %b want 0", INT); end
        pulse_eoi();
        n_cmp++; if (ISR !== 8'h00) begin n_err++; $display("FAIL nest_eoi3: got %h want 00", ISR); end
        clk(1);
        n_cmp++; if (INT !== 1'b1) begin n_err++; $display("FAIL nest_ir5_int: got %b want 1", INT); end
        pulse_inta();
        n_cmp++; if (IRR_CLR !== 8'h20) begin n_err++; $display("FAIL nest_ir5_clr: got %h want 20", IRR_CLR); end
        IRR = '0; pulse_inta();
        n_cmp++; if (DATA_OUT !== {vb, 3'd5}) begin n_err++; $display("FAIL nest_vec5: got %h want %h", DATA_OUT, {vb, 3'd5}); end
        pulse_eoi();
    endtask

    task automatic test_eoi_precedence();
        int lo, hi;
        logic [7:0] m_hi;
        lo = $urandom_range(7, 4); hi = $urandom_range(3, 0);
        m_hi = 8'b1 << hi;
        AEOI = 0; ROTATE_MODE = 0;
        service(lo); service(hi);
        n_cmp++; if (ISR !== (m_hi | (8'b1 << lo))) begin n_err++; $display("FAIL eoi_two_levels: got %h", ISR); end
        EOI_CMD = 1; SEOI_CMD = 1; SEOI_LEVEL = 3'(lo); clk(1); EOI_CMD = 0; SEOI_CMD = 0;
        n_cmp++; if (ISR !== m_hi) begin n_err++; $display("FAIL eoi_seoi_wins: got %h want %h", ISR, m_hi); end
        pulse_eoi();
        n_cmp++; if (ISR !== 8'h00) begin n_err++; $display("FAIL eoi_clear_last: got %h want 00", ISR); end
        pulse_eoi();
        n_cmp++; if (ISR !== 8'h00 || INT !== 1'b0) begin n_err++; $display("FAIL eoi_noop: got isr %h int %b want 00/0", ISR, INT); end
    endtask

    task automatic test_spurious();
        logic [4:0] vb;
        vb = 5'($urandom); VECTOR_BASE = vb;
        IRR = 8'b1 << $urandom_range(7, 0); clk(1);
        n_cmp++; if (INT !== 1'b1) begin n_err++; $display("FAIL spur_int: got %b want 1", INT); end
        IRR = '0; pulse_inta();
        n_cmp++; if (ISR !== 8'h00 || IRR_CLR !== 8'h00 || INT !== 1'b0) begin
            n_err++; $display("FAIL spur_ack1: got isr %h clr %h int %b want 00/00/0", ISR, IRR_CLR, INT); end
        pulse_inta();
        n_cmp++; if (DATA_VALID !== 1'b1 || DATA_OUT !== {vb, 3'd7}) begin
            n_err++; $display("FAIL spur_vector: got %b/%h want 1/%h", DATA_VALID, DATA_OUT, {vb, 3'd7}); end
        clk(1);
    endtask

    task automatic test_timeout();
        int lvl, lvl2;
        logic [7:0] m;
        logic saw_valid;
        lvl = $urandom_range(7, 0); m = 8'b1 << lvl;
        AEOI = 0; ROTATE_MODE = 0;
        IRR = m; clk(1); pulse_inta(); IRR = '0;
        saw_valid = 1'b0;
        for (int i = 0; i < TO; i++) begin clk(1); if (DATA_VALID) saw_valid = 1'b1; end
        n_cmp++; if (ISR !== m) begin n_err++; $display("FAIL timeout_early: got %h want %h", ISR, m); end
        clk(1); if (DATA_VALID) saw_valid = 1'b1;
        n_cmp++; if (ISR !== 8'h00) begin n_err++; $display("FAIL timeout_clear: got %h want 00", ISR); end
        n_cmp++; if (saw_valid !== 1'b0) begin n_err++; $display("FAIL timeout_no_vector: got %b want 0", saw_valid); end
        clk(3);
        n_cmp++; if (INT !== 1'b0) begin n_err++; $display("FAIL timeout_no_int: got %b want 0", INT); end
        lvl2 = $urandom_range(7, 0);
        IRR = 8'b1 << lvl2; clk(1);
        n_cmp++; if (INT !== 1'b1) begin n_err++; $display("FAIL timeout_new_int: got %b want 1", INT); end
        pulse_inta(); IRR = '0; pulse_inta(); pulse_seoi(lvl2);
    endtask

    task automatic test_rotate_aeoi();
        logic [4:0] vb;
        int exp;
        ROTATE_MODE = 1; AEOI = 1; IRR = 8'hFF; clk(1);
        for (int i = 0; i < 9; i++) begin
            vb = 5'($urandom); VECTOR_BASE = vb;
            exp = m_cand(IRR, 8'h00, m_p());
            pulse_inta();
            n_cmp++; if (IRR_CLR !== (8'b1 << exp)) begin n_err++; $display("FAIL rot_clr_%0d: got %h want lvl %0d", i, IRR_CLR, exp); end
            pulse_inta();
            n_cmp++; if (DATA_OUT !== {vb, 3'(exp)} || ISR !== 8'h00) begin
                n_err++; $display("FAIL rot_vec_%0d: got %h isr %h want %h/00", i, DATA_OUT, ISR, {vb, 3'(exp)}); end
            lp_m = exp;
            clk(1);
            n_cmp++; if (INT !== 1'b1) begin n_err++; $display("FAIL rot_b2b_%0d: got %b want 1", i, INT); end
        end
        IRR = '0; pulse_inta(); pulse_inta();
    endtask

    task automatic test_random();
        logic [4:0] vb;
        logic [7:0] irr;
        int exp;
        logic aeoi;
        for (int i = 0; i < 16; i++) begin
            ROTATE_MODE = 1'($urandom); aeoi = 1'($urandom); AEOI = aeoi;
            vb = 5'($urandom); VECTOR_BASE = vb;
            irr = 8'($urandom_range(255, 1)); IRR = irr; clk(1);
            n_cmp++; if (INT !== 1'b1) begin n_err++; $display("FAIL rnd_int_%0d: got %b want 1", i, INT); end
            exp = m_cand(irr, 8'h00, m_p());
            pulse_inta();
            n_cmp++; if (IRR_CLR !== (8'b1 << exp)) begin n_err++; $display("FAIL rnd_clr_%0d: got %h want lvl %0d", i, IRR_CLR, exp); end
            irr = irr & ~(8'b1 << exp); IRR = irr;
            pulse_inta();
            n_cmp++; if (DATA_OUT !== {vb, 3'(exp)}) begin n_err++; $display("FAIL rnd_vec_%0d: got %h want %h", i, DATA_OUT, {vb, 3'(exp)}); end
            if (!aeoi) pulse_eoi();
            if (ROTATE_MODE) lp_m = exp;
            n_cmp++; if (ISR !== 8'h00) begin n_err++; $display("FAIL rnd_isr_%0d: got %h want 00", i, ISR); end
        end
        IRR = '0; ROTATE_MODE = 0; AEOI = 0; clk(2);
        if (INT) begin pulse_inta(); pulse_inta(); end
    endtask

    task automatic test_reset_mid();
        ROTATE_MODE = 1; AEOI = 0;
        pulse_seoi(2); lp_m = 2;
        IRR = 8'h04; clk(1); pulse_inta(); IRR = '0;
        n_cmp++; if (ISR !== 8'h04) begin n_err++; $display("FAIL rstmid_isr_before: got %h want 04", ISR); end
        RST = 1; clk(1); RST = 0; lp_m = 7;
        n_cmp++; if (ISR !== 8'h00 || INT !== 1'b0 || IRR_CLR !== 8'h00 || DATA_VALID !== 1'b0) begin
            n_err++; $display("FAIL rstmid_regs: got isr %h int %b clr %h dv %b", ISR, INT, IRR_CLR, DATA_VALID); end
        pulse_inta();
        n_cmp++; if (ISR !== 8'h00 || DATA_VALID !== 1'b0 || INT !== 1'b0) begin
            n_err++; $display("FAIL rstmid_inta_ignored: got isr %h dv %b int %b", ISR, DATA_VALID, INT); end
        IRR = 8'h0A; clk(1); pulse_inta();
        n_cmp++; if (IRR_CLR !== (8'b1 << m_cand(8'h0A, 8'h00, m_p()))) begin
            n_err++; $display("FAIL rstmid_lp_reset: got %h want 02", IRR_CLR); end
        IRR = '0; pulse_inta();
    endtask

    initial begin
        clk(2);
        RST = 1'b0;
        test_reset();
        test_basic(3, 5'b01000);
        test_basic($urandom_range(7, 0), 5'($urandom));
        test_nesting();
        test_eoi_precedence();
        test_spurious();
        test_timeout();
        test_rotate_aeoi();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
